// File: rtl/rr_arbiter_fsm.sv
// rtl/rr_arbiter_fsm.sv - 4-requester round-robin arbiter, one-hot FSM, registered grant (optional ARB_TIMEOUT_EN forced release)
module rr_arbiter_fsm #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [1:0]      gnt_id,
  output logic            busy,
  output logic            timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    GRANT   = 3'b010,
    RELEASE = 3'b100
  } state_t;

  // The hold counter must be able to reach MAX_HOLD-1 without wrapping.
  if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MAX_HOLD");
  end

  state_t     state;
  logic [1:0] last_owner;
  logic [1:0] sel;
  logic [1:0] cand;
  logic       found;
  logic       owner_req;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_expired;

  assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
  assign timeout = 1'b0;
`endif

  assign owner_req = req[gnt_id];

  // Round-robin pick: first asserted request after last_owner, wrapping mod 4.
  always_comb begin
    sel   = last_owner;
    cand  = last_owner;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_owner + 2'(k);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Arbiter FSM with all outputs registered alongside the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_valid  <= 1'b0;
      gnt_id     <= 2'd0;
      busy       <= 1'b0;
      last_owner <= 2'd3;
`ifdef ARB_TIMEOUT_EN
      hold_cnt   <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req != '0) begin
            state      <= GRANT;
            gnt        <= '0;
            gnt[sel]   <= 1'b1;
            gnt_valid  <= 1'b1;
            gnt_id     <= sel;
            busy       <= 1'b1;
            last_owner <= sel;
`ifdef ARB_TIMEOUT_EN
            hold_cnt   <= '0;
`endif
          end
        end

        GRANT: begin
`ifdef ARB_TIMEOUT_EN
          if (owner_req && hold_expired) begin
            // Owner overstayed: drop it; last_owner already makes it lowest priority.
            state     <= RELEASE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= 2'd0;
            timeout   <= 1'b1;
          end else if (owner_req) begin
            if (hold_cnt != '1) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end else begin
            state     <= RELEASE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= 2'd0;
          end
`else
          if (!owner_req) begin
            state     <= RELEASE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= 2'd0;
          end
`endif
        end

        RELEASE: begin
          // Turnaround cycle; always back to IDLE so the next pick starts clean.
          state <= IDLE;
          busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          timeout <= 1'b0;
`endif
        end

        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          gnt_id    <= 2'd0;
          busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          timeout   <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter_fsm.md
Name: rr_arbiter_fsm

Overview:
- 4-requester round-robin arbiter for a shared single-port resource (bus or memory port).
- Built as a one-hot FSM with a registered one-hot grant vector.
- Holds a grant while the owner keeps its request asserted, then inserts one turnaround cycle.
- Sits between requesting masters and the resource mux; gnt_id drives the mux select.

Parameters:
- NREQ, 4, number of requesters (fixed at 4; gnt_id width is 2).
- MAX_HOLD, 16, maximum consecutive grant cycles before forced release (ARB_TIMEOUT_EN only).
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NREQ  request per requester, level-sensitive.
- gnt  output  NREQ  one-hot grant, registered.
- gnt_valid  output  1  high when any gnt bit is high.
- gnt_id  output  2  binary index of the current owner; 0 when gnt_valid=0.
- busy  output  1  high in GRANT or RELEASE.
- timeout  output  1  one-cycle pulse on forced release (0 when ARB_TIMEOUT_EN is undefined).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, busy=0, timeout=0.
  - last_owner=3, so requester 0 has first priority; hold counter=0.
  - All outputs return to these values immediately, including mid-grant.
- States are one-hot: IDLE=3'b001, GRANT=3'b010, RELEASE=3'b100. Any other encoding goes to IDLE on the next edge.
- IDLE:
  - If req!=0 at a rising edge, select the first asserted bit searching last_owner+1, +2, +3, +4 (mod 4).
  - At that edge: gnt=onehot(sel), gnt_id=sel, last_owner=sel, counter=0, go to GRANT.
  - Latency is one edge from req sampled high to gnt high.
  - If req==0, stay in IDLE.
- GRANT:
  - Stay in GRANT while req[gnt_id]=1; the counter increments each cycle and saturates.
  - When req[gnt_id]=0 at an edge: gnt clears at that edge, go to RELEASE.
  - Requests from other requesters never preempt the owner.
- RELEASE:
  - Exactly one cycle with gnt=0 and busy=1, then IDLE unconditionally.
  - Minimum gap between consecutive grants is 2 cycles (RELEASE + IDLE).
- Fairness: a requester that holds req continuously is granted within 3 grant tenures after the current one.
- Simultaneous events:
  - All 4 requests rising together from reset: grant order is 0, 1, 2, 3.
  - A req that drops and rises in the same GRANT cycle is irrelevant; only the sampled level counts.
- gnt_valid and gnt_id are registered alongside gnt; no combinational path from req to any output.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when counter==MAX_HOLD-1 and req[gnt_id] is still 1, force release at that edge.
  - gnt clears, timeout pulses high for one cycle (the RELEASE cycle), and the state goes to RELEASE.
  - The owner is then lowest priority via last_owner.
  - An owner may re-win later if no other request is pending.
- Undefined: no counter or timeout logic; a grant is held indefinitely while req is held; timeout is tied to 0.

Test Plan:
- Reset then req=4'b0000 for 10 cycles -> gnt=0, busy=0, gnt_valid=0 throughout.
- req=4'b1111 held constantly, no timeout, each owner drops its req 3 cycles after its grant, then re-raises it after RELEASE -> grant order 0,1,2,3,0; each tenure 3 cycles; gap 2 cycles.
- req=4'b0100 at cycle 0 -> gnt=4'b0100 and gnt_id=2 from edge 1; req[1] raised at cycle 3 -> gnt unchanged until req[2] drops; then RELEASE, IDLE, and gnt=4'b0010.
- Assert reset_n=0 asynchronously mid-GRANT with gnt=4'b1000 -> gnt=0 immediately; after release, req=4'b1001 -> requester 0 granted first (last_owner=3).
- ARB_TIMEOUT_EN defined, MAX_HOLD=16, req=4'b0011 held -> gnt[0] for 16 cycles, timeout pulse, gnt[1] for 16 cycles, then back to 0.
- ARB_TIMEOUT_EN undefined, req=4'b0001 held for 100 cycles -> gnt=4'b0001 continuous, timeout=0.
